// File: rtl/button_input.sv
// button_input: synchronise and debounce the raw keys, auto-repeat left/right,
// and hold move/rotate requests until the game control FSM acknowledges them.
module button_input #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_left_n,
  input  logic key_right_n,
  input  logic key_rotate_n,
  input  logic key_go_n,
  input  logic ack_move,
  input  logic ack_rotate,
  output logic left,
  output logic right,
  output logic rotate,
  output logic go
);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_st_t;
  logic [3:0] raw, sync1_q, sync2_q, db;
  logic [2:0] db_prev_q, press;
  logic [1:0] move_ev;
  logic left_q, left_d, right_q, right_d, rotate_q, rotate_d;
  // Bit order: 0 left, 1 right, 2 rotate, 3 go; inverted so 1 = pressed.
  assign raw = ~{key_go_n, key_rotate_n, key_right_n, key_left_n};
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_prev_q <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db[2:0];
    end
  end
  assign press = db[2:0] & ~db_prev_q;
  for (genvar k = 0; k < 4; k++) begin : g_deb
    logic db_q;
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        db_q  <= 1'b0;
        cnt_q <= '0;
      end else if (sync2_q[k] == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
        db_q  <= ~db_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
    assign db[k] = db_q;
  end
  for (genvar j = 0; j < 2; j++) begin : g_rep
    rep_st_t st_q;
    logic [CNT_W-1:0] cnt_q;
    logic at_delay, at_rate;
    assign at_delay   = (st_q == DELAY) && (cnt_q == CNT_W'(REPEAT_DELAY - 1));
    assign at_rate    = (st_q == REPEAT) && (cnt_q == CNT_W'(REPEAT_RATE - 1));
    assign move_ev[j] = (st_q == IDLE) ? press[j] : db[j] && (at_delay || at_rate);
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        st_q  <= IDLE;
        cnt_q <= '0;
      end else if (st_q == IDLE) begin
        st_q  <= press[j] ? DELAY : IDLE;
        cnt_q <= '0;
      end else if (!db[j]) begin
        st_q  <= IDLE;
        cnt_q <= '0;
      end else if (at_delay || at_rate) begin
        st_q  <= REPEAT;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
  // Simultaneous left and right events cancel; otherwise the newest direction wins.
  always_comb begin
    left_d   = (move_ev[0] && !move_ev[1]) ? 1'b1 :
               (move_ev[1] && !move_ev[0]) ? 1'b0 :
               ack_move ? 1'b0 : left_q;
    right_d  = (move_ev[1] && !move_ev[0]) ? 1'b1 :
               (move_ev[0] && !move_ev[1]) ? 1'b0 :
               ack_move ? 1'b0 : right_q;
    rotate_d = press[2] ? 1'b1 : ack_rotate ? 1'b0 : rotate_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      rotate_q <= 1'b0;
    end else begin
      left_q   <= left_d;
      right_q  <= right_d;
      rotate_q <= rotate_d;
    end
  end
  assign left   = left_q;
  assign right  = right_q;
  assign rotate = rotate_q;
  assign go     = db[3];
endmodule
